dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_pkg.sv | 18 +
 rtl/rr_arbiter_2.sv | 29 ++
 rtl/dmem_arbiter.sv | 138 +++++++++++++
 tb/tb_dmem_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the FSM state enum, the memory-mapped port addresses and the width defaults.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR    = 2'd1,
        ACCESS  = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;

    localparam logic [9:0] INPUT_PORT  = 10'h3FE;
    localparam logic [9:0] OUTPUT_PORT = 10'h3FF;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: the requester not served last wins a tie.
// After reset the pointer says B was served last, so A has priority.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic last_b;

    always_comb begin
        grant = 2'b00;
        if (req[0] && (!req[1] || last_b))
            grant[0] = 1'b1;
        else if (req[1])
            grant[1] = 1'b1;
    end

    // Pointer moves only when the grant is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_b <= 1'b1;
        else if (update && (grant != 2'b00))
            last_b <= grant[1];
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a core (A) and a loader (B) onto a single-ported memory manager.
// Each access walks IDLE -> ADDR -> ACCESS -> CAPTURE; ack pulses in the following cycle.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic              a_err,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic              b_err,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_addr_write_en,
    output logic              mem_write_en,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] IN_PORT  = ADDR_W'(INPUT_PORT);
    localparam logic [ADDR_W-1:0] OUT_PORT = ADDR_W'(OUTPUT_PORT);

    state_t            state, state_nxt;
    logic [1:0]        elig, grant;
    logic              take;
    logic              owner_b, we_q, guard_q;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata, cap_data;

    // A requester being acked this cycle still holds req; mask it so the other side gets the slot.
    assign elig = {b_req & ~b_ack, a_req & ~a_ack};
    assign take = (state == IDLE) && (grant != 2'b00);

    rr_arbiter_2 u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (elig),
        .update (take),
        .grant  (grant)
    );

    assign sel_we    = grant[1] ? b_we    : a_we;
    assign sel_addr  = grant[1] ? b_addr  : a_addr;
    assign sel_wdata = grant[1] ? b_wdata : a_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant != 2'b00) state_nxt = ADDR;
            ADDR:    state_nxt = ACCESS;
            ACCESS:  state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_addr_write_en = 1'b0;
        mem_write_en      = 1'b0;
        mem_read_en       = 1'b0;
        case (state)
            ADDR:   mem_addr_write_en = 1'b1;
            ACCESS: begin
                mem_write_en = we_q & ~guard_q;
                mem_read_en  = ~we_q & ~guard_q;
            end
            default: ;
        endcase
    end

    // Everything about the transaction is captured at grant so later req/addr changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_b   <= 1'b0;
            we_q      <= 1'b0;
            guard_q   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (take) begin
            owner_b   <= grant[1];
            we_q      <= sel_we;
            guard_q   <= sel_we ? (sel_addr == IN_PORT) : (sel_addr == OUT_PORT);
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
        end
    end

    assign cap_data = (we_q || guard_q) ? '0 : mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_ack   <= 1'b0;
            a_err   <= 1'b0;
            a_rdata <= '0;
            b_ack   <= 1'b0;
            b_err   <= 1'b0;
            b_rdata <= '0;
        end else begin
            a_ack <= 1'b0;
            a_err <= 1'b0;
            b_ack <= 1'b0;
            b_err <= 1'b0;
            if (state == CAPTURE) begin
                if (owner_b) begin
                    b_ack   <= 1'b1;
                    b_err   <= guard_q;
                    b_rdata <= cap_data;
                end else begin
                    a_ack   <= 1'b1;
                    a_err   <= guard_q;
                    a_rdata <= cap_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stimulus pushes expected acks into a scoreboard,
// a negedge monitor pops and compares them; strobe timing is checked inline.
module tb_dmem_arbiter;

    logic       clk, rst_n;
    logic       a_req, a_we, b_req, b_we;
    logic [9:0] a_addr, b_addr, mem_addr;
    logic [7:0] a_wdata, b_wdata, a_rdata, b_rdata, mem_wdata, mem_rdata;
    logic       a_ack, a_err, b_ack, b_err;
    logic       mem_addr_write_en, mem_write_en, mem_read_en;

    typedef struct {
        bit         port_b;
        logic [7:0] rdata;
        bit         err;
    } exp_t;

    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] mem [1024];

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
        .mem_addr_write_en(mem_addr_write_en), .mem_write_en(mem_write_en),
        .mem_read_en(mem_read_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory manager model with registered read data.
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_addr] <= mem_wdata;
        if (mem_read_en)  mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input bit pb, input logic [7:0] rd, input bit er);
        exp_t e;
        e.port_b = pb;
        e.rdata  = rd;
        e.err    = er;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (a_ack || b_ack)) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_ack", 1, 0);
            end else begin
                e = sb.pop_front();
                check("sb_port", int'(b_ack), int'(e.port_b));
                check("sb_rdata", int'(b_ack ? b_rdata : a_rdata), int'(e.rdata));
                check("sb_err", int'(b_ack ? b_err : a_err), int'(e.err));
            end
        end
        if (mem_addr_write_en || mem_write_en || mem_read_en)
            check("strobe_excl", $countones({mem_addr_write_en, mem_write_en, mem_read_en}), 1);
    end

    // One transaction on a single port; counts strobes and records the ack cycle (0 = timeout).
    task automatic do_txn(input bit pb, input bit we, input logic [9:0] addr, input logic [7:0] wd,
                          output int ack_cyc, output int wr_cnt, output int rd_cnt,
                          output logic [7:0] wd_seen);
        ack_cyc = 0; wr_cnt = 0; rd_cnt = 0; wd_seen = 8'h00;
        if (pb) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wd; end
        else    begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wd; end
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (mem_write_en) begin wr_cnt++; wd_seen = mem_wdata; end
            if (mem_read_en)  rd_cnt++;
            if (pb ? b_ack : a_ack) begin
                ack_cyc = c;
                if (pb) b_req = 0; else a_req = 0;
                break;
            end
        end
        if (pb) b_req = 0; else a_req = 0;
    endtask

    task automatic pair(output int ca, output int cb);
        ca = 0; cb = 0;
        a_req = 1; a_we = 0; a_addr = 10'h010;
        b_req = 1; b_we = 0; b_addr = 10'h020;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (a_ack && ca == 0) begin ca = c; a_req = 0; end
            if (b_ack && cb == 0) begin cb = c; b_req = 0; end
            if (ca != 0 && cb != 0) break;
        end
        a_req = 0; b_req = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;
    endtask

    initial begin
        int ack_c, wr_c, rd_c, ca, cb;
        logic [7:0] wd;
        rst_n = 0;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h00F] = 8'h99; mem[10'h010] = 8'h11; mem[10'h020] = 8'h22; mem[10'h3FE] = 8'h5A;
        repeat (2) @(negedge clk);
        check("rst_flags", int'({a_ack, b_ack, a_err, b_err, mem_addr_write_en, mem_write_en, mem_read_en}), 0);
        check("rst_mem_addr", int'(mem_addr), 0);
        check("rst_rdata", int'({a_rdata, b_rdata}), 0);
        rst_n = 1;

        // Read 0x00F, address changed while in ADDR.
        @(negedge clk);
        sb.push_back(mk(0, 8'h99, 0));
        a_req = 1; a_we = 0; a_addr = 10'h00F;
        @(negedge clk);
        check("c1_strobes", int'({mem_addr_write_en, mem_write_en, mem_read_en}), 3'b100);
        check("c1_mem_addr", int'(mem_addr), 10'h00F);
        a_addr = 10'h055;
        @(negedge clk);
        check("c2_strobes", int'({mem_addr_write_en, mem_write_en, mem_read_en}), 3'b001);
        check("c2_mem_addr", int'(mem_addr), 10'h00F);
        @(negedge clk);
        check("c3_strobes", int'({mem_addr_write_en, mem_write_en, mem_read_en}), 3'b000);
        check("c3_mem_addr", int'(mem_addr), 10'h00F);
        @(negedge clk);
        check("c4_a_ack", int'(a_ack), 1);
        a_req = 0;
        @(negedge clk);
        check("ack_one_cycle", int'(a_ack), 0);
        check("rdata_hold", int'(a_rdata), 8'h99);
        check("mem_addr_hold", int'(mem_addr), 10'h00F);

        // Round-robin: simultaneous requests after reset, A wins.
        do_reset();
        sb.push_back(mk(0, 8'h11, 0));
        sb.push_back(mk(1, 8'h22, 0));
        pair(ca, cb);
        check("rr1_a_cycle", ca, 4);
        check("rr1_b_cycle", cb, 8);
        @(negedge clk);
        sb.push_back(mk(0, 8'h11, 0));
        do_txn(0, 0, 10'h010, 8'h00, ack_c, wr_c, rd_c, wd);
        check("solo_a_cycle", ack_c, 4);
        @(negedge clk);
        sb.push_back(mk(1, 8'h22, 0));
        sb.push_back(mk(0, 8'h11, 0));
        pair(ca, cb);
        check("rr2_b_cycle", cb, 4);
        check("rr2_a_cycle", ca, 8);

        // B writes to the output port: allowed.
        @(negedge clk);
        sb.push_back(mk(1, 8'h00, 0));
        do_txn(1, 1, 10'h3FF, 8'h8C, ack_c, wr_c, rd_c, wd);
        check("wout_ack", ack_c, 4);
        check("wout_wr_cnt", wr_c, 1);
        check("wout_wdata", int'(wd), 8'h8C);
        check("wout_rd_cnt", rd_c, 0);

        // Guarded accesses: write to input port, read from output port.
        @(negedge clk);
        sb.push_back(mk(0, 8'h00, 1));
        do_txn(0, 1, 10'h3FE, 8'h55, ack_c, wr_c, rd_c, wd);
        check("gw_ack", ack_c, 4);
        check("gw_strobes", wr_c + rd_c, 0);
        @(negedge clk);
        sb.push_back(mk(0, 8'h00, 1));
        do_txn(0, 0, 10'h3FF, 8'h00, ack_c, wr_c, rd_c, wd);
        check("gr_ack", ack_c, 4);
        check("gr_strobes", wr_c + rd_c, 0);

        // Ordinary write/read-back and an allowed read of the input port.
        @(negedge clk);
        sb.push_back(mk(0, 8'h00, 0));
        do_txn(0, 1, 10'h040, 8'h77, ack_c, wr_c, rd_c, wd);
        check("w040_wr_cnt", wr_c, 1);
        @(negedge clk);
        sb.push_back(mk(0, 8'h77, 0));
        do_txn(0, 0, 10'h040, 8'h00, ack_c, wr_c, rd_c, wd);
        check("r040_rd_cnt", rd_c, 1);
        @(negedge clk);
        sb.push_back(mk(1, 8'h5A, 0));
        do_txn(1, 0, 10'h3FE, 8'h00, ack_c, wr_c, rd_c, wd);
        check("rin_ack", ack_c, 4);

        // Reset during ACCESS: transaction dropped, held req re-served afterwards.
        @(negedge clk);
        a_req = 1; a_we = 0; a_addr = 10'h00F;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_access", int'(mem_read_en), 1);
        rst_n = 0;
        #1;
        check("mid_rst_flags", int'({a_ack, b_ack, a_err, b_err, mem_addr_write_en, mem_write_en, mem_read_en}), 0);
        check("mid_rst_mem_addr", int'(mem_addr), 0);
        check("mid_rst_rdata", int'({a_rdata, b_rdata}), 0);
        @(negedge clk);
        check("rst_no_ack", int'(a_ack), 0);
        rst_n = 1;
        sb.push_back(mk(0, 8'h99, 0));
        ack_c = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (a_ack) begin ack_c = c; a_req = 0; break; end
        end
        a_req = 0;
        check("post_rst_ack", ack_c, 4);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
